irq_event_logger: RTL and testbench

IRQ_EVENT_LOGGER -- requirements
Module: irq_event_logger

---
 rtl/irq_event_logger_pkg.sv | 31 +++
 rtl/irq_log_fifo.sv | 69 ++++++
 rtl/irq_event_logger.sv | 151 +++++++++++++++
 tb/tb_irq_event_logger.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_event_logger_pkg.sv
// ============================================================================
// Module  : irq_event_logger_pkg
// Brief   : Register map, bit positions and widths for irq_event_logger.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_event_logger_pkg;

  localparam int c_TS_W = 32;

  localparam logic [2:0] c_ADDR_STATUS   = 3'd0;
  localparam logic [2:0] c_ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] c_ADDR_DATA_LO  = 3'd2;
  localparam logic [2:0] c_ADDR_DATA_HI  = 3'd3;
  localparam logic [2:0] c_ADDR_TS_LO    = 3'd4;
  localparam logic [2:0] c_ADDR_TS_HI    = 3'd5;
  localparam logic [2:0] c_ADDR_DROP_CNT = 3'd6;

  localparam int c_ST_NOT_EMPTY = 0;
  localparam int c_ST_FULL      = 1;
  localparam int c_ST_OVERFLOW  = 2;
  localparam int c_ST_LEVEL_LSB = 4;

  localparam int c_CTRL_CAP_EN = 0;
  localparam int c_CTRL_IRQ_EN = 1;
  localparam int c_CTRL_FLUSH  = 2;

endpackage

`default_nettype wire

// File: rtl/irq_log_fifo.sv
// ============================================================================
// Module  : irq_log_fifo
// Brief   : Synchronous FIFO with flush; a push into a full FIFO is accepted
//           only when a pop happens in the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_log_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] c_FULL_LEVEL = LW'(DEPTH);
  localparam logic [AW-1:0] c_PTR_ONE    = AW'(1);
  localparam logic [LW-1:0] c_CNT_ONE    = LW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((r_count != c_FULL_LEVEL) | w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == c_FULL_LEVEL);
  assign empty = (r_count == '0);
  assign level = r_count;

endmodule

`default_nettype wire

// File: rtl/irq_event_logger.sv
// ============================================================================
// Module  : irq_event_logger
// Brief   : Timestamps rising edges of irq_in into a FIFO readable over an
//           Avalon-MM slave. Optional drop counter: IRQ_LOG_DROP_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_event_logger
  import irq_event_logger_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = c_TS_W
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        irq_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [TS_W-1:0] r_ts;
  logic            r_irq_d;
  logic            r_cap_en;
  logic            r_irq_en;
  logic            r_overflow;
  logic [15:0]     r_hold;
  logic [15:0]     r_snap;

  logic            w_rd;
  logic            w_wr;
  logic            w_event;
  logic            w_flush;
  logic            w_pop;
  logic            w_drop;
  logic [TS_W-1:0] w_head;
  logic            w_full;
  logic            w_empty;
  logic [LW-1:0]   w_level;
  logic [3:0]      w_level4;
  logic [15:0]     w_rdata;
  logic            w_unused_wdata;

  assign w_rd    = chipselect & ~read_n;
  assign w_wr    = chipselect & ~write_n;
  assign w_event = r_cap_en & irq_in & ~r_irq_d;
  assign w_flush = w_wr & (address == c_ADDR_CONTROL) & writedata[c_CTRL_FLUSH];
  assign w_pop   = w_rd & (address == c_ADDR_DATA_HI) & ~w_empty;
  // Flush discards a coinciding event, so it never counts as a drop.
  assign w_drop  = w_event & w_full & ~w_pop & ~w_flush;

  assign w_level4       = 4'(w_level);
  assign w_unused_wdata = &{1'b0, writedata[15:3]};
  assign irq            = r_irq_en & ~w_empty;

  irq_log_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TS_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_event),
    .pop     (w_pop),
    .flush   (w_flush),
    .din     (r_ts),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

`ifdef IRQ_LOG_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (w_wr && address == c_ADDR_DROP_CNT) begin
      r_drop_cnt <= '0;
    end else if (w_drop && r_drop_cnt != 16'hFFFF) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (address)
      c_ADDR_STATUS: begin
        w_rdata[c_ST_NOT_EMPTY]        = ~w_empty;
        w_rdata[c_ST_FULL]             = w_full;
        w_rdata[c_ST_OVERFLOW]         = r_overflow;
        w_rdata[c_ST_LEVEL_LSB +: 4]   = w_level4;
      end
      c_ADDR_CONTROL: begin
        w_rdata[c_CTRL_CAP_EN] = r_cap_en;
        w_rdata[c_CTRL_IRQ_EN] = r_irq_en;
      end
      c_ADDR_DATA_LO:  w_rdata = w_empty ? 16'h0000 : w_head[15:0];
      c_ADDR_DATA_HI:  w_rdata = r_hold;
      c_ADDR_TS_LO:    w_rdata = r_ts[15:0];
      c_ADDR_TS_HI:    w_rdata = r_snap;
`ifdef IRQ_LOG_DROP_CNT_EN
      c_ADDR_DROP_CNT: w_rdata = r_drop_cnt;
`else
      c_ADDR_DROP_CNT: w_rdata = '0;
`endif
      default:         w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata   <= '0;
      r_irq_d    <= 1'b0;
      r_ts       <= '0;
      r_cap_en   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_overflow <= 1'b0;
      r_hold     <= '0;
      r_snap     <= '0;
    end else begin
      r_irq_d <= irq_in;
      r_ts    <= (w_wr && address == c_ADDR_TS_LO) ? '0 : r_ts + TS_W'(1);
      if (w_rd) begin
        readdata <= w_rdata;
        if (address == c_ADDR_DATA_LO) r_hold <= w_empty ? 16'h0000 : w_head[16 +: 16];
        if (address == c_ADDR_TS_LO)   r_snap <= r_ts[16 +: 16];
      end
      if (w_wr && address == c_ADDR_CONTROL) begin
        r_cap_en <= writedata[c_CTRL_CAP_EN];
        r_irq_en <= writedata[c_CTRL_IRQ_EN];
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_wr && address == c_ADDR_STATUS) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_event_logger.sv
// ============================================================================
// Module  : tb_irq_event_logger
// Brief   : Directed and random checks of irq_event_logger against a
//           queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_event_logger;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset_n;
  logic        irq_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  irq_event_logger #(.DEPTH(DEPTH), .TS_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_ts;
  bit          m_ovf, m_cap, m_ien, m_prev;
  logic [15:0] m_hold, m_snap, m_rd, m_drop;

  function automatic bit m_irq();
    return m_ien && (m_q.size() != 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit rd, wr, ev, pop, drop;
    if (!reset_n) begin
      m_q.delete();
      m_ts = 0; m_ovf = 0; m_cap = 0; m_ien = 0; m_prev = 0;
      m_hold = 0; m_snap = 0; m_rd = 0; m_drop = 0;
      return;
    end
    rd   = chipselect && !read_n;
    wr   = chipselect && !write_n;
    ev   = m_cap && irq_in && !m_prev;
    pop  = rd && address == 3'd3 && m_q.size() != 0;
    drop = 0;
    if (rd) begin
      case (address)
        3'd0: m_rd = {8'h00, 4'(m_q.size()), 1'b0, m_ovf, m_q.size() == DEPTH, m_q.size() != 0};
        3'd1: m_rd = {14'h0, m_ien, m_cap};
        3'd2: begin
          m_rd   = (m_q.size() != 0) ? m_q[0][15:0]  : 16'h0;
          m_hold = (m_q.size() != 0) ? m_q[0][31:16] : 16'h0;
        end
        3'd3: m_rd = m_hold;
        3'd4: begin m_rd = m_ts[15:0]; m_snap = m_ts[31:16]; end
        3'd5: m_rd = m_snap;
`ifdef IRQ_LOG_DROP_CNT_EN
        3'd6: m_rd = m_drop;
`else
        3'd6: m_rd = 16'h0;
`endif
        default: m_rd = 16'h0;
      endcase
    end
    if (wr && address == 3'd1 && writedata[2]) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (ev) begin
        if (m_q.size() == DEPTH) drop = 1;
        else m_q.push_back(m_ts);
      end
    end
    if (drop) m_ovf = 1;
    else if (wr && address == 3'd0) m_ovf = 0;
    if (wr && address == 3'd6) m_drop = 0;
    else if (drop && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    if (wr && address == 3'd1) begin
      m_cap = writedata[0];
      m_ien = writedata[1];
    end
    m_ts   = (wr && address == 3'd4) ? 32'h0 : m_ts + 32'd1;
    m_prev = irq_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("cyc_rdata", readdata, m_rd);
    check("cyc_irq", irq, m_irq());
  endtask

  task automatic idle();
    chipselect = 0; read_n = 1; write_n = 1; address = 0; writedata = 0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    tick();
    idle();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    chipselect = 1; read_n = 0; address = a;
    tick();
    idle();
    d = readdata;
  endtask

  task automatic pulse();
    irq_in = 1; tick();
    irq_in = 0; tick();
  endtask

  initial begin
    logic [15:0] d, lo, hi, prev;
    logic [31:0] t_new;
    reset_n = 0; irq_in = 0;
    idle();
    repeat (3) tick();
    check("rst_readdata", readdata, 16'h0000);
    check("rst_irq", irq, 1'b0);
    reset_n = 1;

    bus_read(3'd0, d); check("rst_status", d, 16'h0000);
    bus_read(3'd1, d); check("rst_control", d, 16'h0000);
    bus_read(3'd5, d); check("rst_ts_hi", d, 16'h0000);
    bus_read(3'd6, d); check("rst_drop", d, 16'h0000);

    // Single event timestamped at counter 100
    bus_write(3'd1, 16'h0001);
    for (int k = 0; k < 200 && m_ts != 32'd100; k++) tick();
    irq_in = 1; tick();
    bus_read(3'd0, d); check("ev_status", d, 16'h0011);
    bus_read(3'd2, d); check("ev_data_lo", d, 16'h0064);
    bus_read(3'd3, d); check("ev_data_hi", d, 16'h0000);
    bus_read(3'd0, d); check("ev_status_empty", d, 16'h0000);
    irq_in = 0; tick();

    // Interrupt follows FIFO occupancy
    bus_write(3'd1, 16'h0003);
    irq_in = 1; tick();
    check("irq_set", irq, 1'b1);
    irq_in = 0;
    bus_read(3'd2, d); check("irq_hold", irq, 1'b1);
    bus_read(3'd3, d); check("irq_clr", irq, 1'b0);

    // Overflow: nine events into eight entries
    bus_write(3'd1, 16'h0005);
    repeat (9) pulse();
    bus_read(3'd0, d); check("ovf_status", d, 16'h0087);
    bus_read(3'd6, d);
`ifdef IRQ_LOG_DROP_CNT_EN
    check("ovf_drop_cnt", d, 16'h0001);
`else
    check("ovf_drop_cnt", d, 16'h0000);
`endif

    // Event coinciding with a pop on a full FIFO
    bus_write(3'd0, 16'h0000);
    t_new = m_ts;
    chipselect = 1; read_n = 0; address = 3'd3; irq_in = 1;
    tick();
    idle(); irq_in = 0;
    bus_read(3'd0, d); check("fullpop_status", d, 16'h0083);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(3'd2, lo);
      bus_read(3'd3, hi);
    end
    check("fullpop_tail", {hi, lo}, t_new);
    bus_read(3'd0, d); check("drained_status", d, 16'h0000);

    // Timestamp clear and monotonic readback
    bus_write(3'd4, 16'h0000);
    bus_read(3'd4, d); check("ts_lo_zero", d, 16'h0000);
    bus_read(3'd5, d); check("ts_hi_zero", d, 16'h0000);
    prev = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      bus_read(3'd4, d);
      check("ts_mono", d > prev, 1'b1);
      prev = d;
    end

    // Flush wins over a coinciding event
    bus_write(3'd1, 16'h0003);
    pulse();
    check("pre_flush_irq", irq, 1'b1);
    chipselect = 1; write_n = 0; address = 3'd1; writedata = 16'h0007; irq_in = 1;
    tick();
    idle(); irq_in = 0;
    check("flush_irq", irq, 1'b0);
    bus_read(3'd0, d); check("flush_status", d, 16'h0000);

    // Reset during a read discards the pending data
    bus_read(3'd1, d); check("ctrl_readback", d, 16'h0003);
    chipselect = 1; read_n = 0; address = 3'd1; reset_n = 0;
    tick();
    check("rst_mid_read", readdata, 16'h0000);
    reset_n = 1; idle();
    tick();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r;
      idle();
      if ($urandom_range(0, 2) == 0) irq_in = ~irq_in;
      r = $urandom_range(0, 9);
      address   = 3'($urandom_range(0, 7));
      writedata = 16'($urandom);
      if (address == 3'd1) begin
        writedata[0] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) != 0) writedata[2] = 1'b0;
      end
      if (r >= 5) begin
        chipselect = 1;
        read_n  = (r == 8);
        write_n = (r < 8);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
